spike_event_logger: RTL and testbench

- Downstream consumer of the LIF neuron's 1-bit spike output.
- Timestamps every spike against a free-running cycle counter and queues the timestamps in a small first-word-fall-through FIFO.
- The FIFO drains over a valid/ready interface toward the readout path (host/IO stage).
- Tracks lost events (FIFO full) with a sticky overflow flag and a saturating drop counter, so raster data is never silently corrupted.

---
 rtl/spike_event_logger.sv | 111 +++++++++++
 tb/tb_spike_event_logger.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/spike_event_logger.sv
// Spike event logger: timestamps each spike from a LIF neuron against a
// free-running cycle counter and queues the timestamps in a small
// first-word-fall-through FIFO that drains over valid/ready. Spikes that
// find the FIFO full are counted (saturating) and flagged (sticky).
module spike_event_logger #(
    parameter int TS_WIDTH = 8,
    parameter int DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       clear,
    input  logic                       spike,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TS_WIDTH-1:0]        out_timestamp,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       overflow,
    output logic [7:0]                 drop_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int FW = PW + 1;

    localparam logic [TS_WIDTH-1:0] TS_ONE   = TS_WIDTH'(1);
    localparam logic [PW-1:0]       PTR_ONE  = PW'(1);
    localparam logic [FW-1:0]       FILL_ONE = FW'(1);
    localparam logic [FW-1:0]       FILL_MAX = FW'(DEPTH);

    logic [TS_WIDTH-1:0] ts;
    logic [TS_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;

    logic full;
    logic do_pop;
    logic do_push;
    logic do_drop;

    // Handshake and push/drop decisions for the current edge.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
        full    = 1'b0;
        do_pop  = 1'b0;
        do_push = 1'b0;
        do_drop = 1'b0;
        full    = (fill_level == FILL_MAX);
        if (!clear) begin
            do_pop = out_valid && out_ready;
            if (en && spike) begin
                // A pop at the same edge frees the slot the new event needs.
                do_push = !full || do_pop;
                do_drop = full && !do_pop;
            end
        end
    end

    // Head of queue; gated so the port reads zero while the FIFO is empty.
    assign out_valid     = (fill_level != '0);
    assign out_timestamp = out_valid ? mem[rd_ptr] : '0;

    // Timestamp counter, pointers, occupancy and drop bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            ts         <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill_level <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            ts         <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill_level <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (en) begin
                ts <= ts + TS_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                fill_level <= fill_level + FILL_ONE;
            end else if (do_pop && !do_push) begin
                fill_level <= fill_level - FILL_ONE;
            end
            if (do_drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

    // Entry storage; the pre-increment ts is the event timestamp.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; occupancy is tracked by fill_level, so stale entries are never visible.
        if (do_push) begin
            mem[wr_ptr] <= ts;
        end
    end

endmodule

// File: tb/tb_spike_event_logger.sv
// Self-checking bench for spike_event_logger: directed scenarios plus
// random traffic, all compared against a queue-based reference model.
module tb_spike_event_logger;

    localparam int TS_WIDTH = 8;
    localparam int DEPTH    = 4;
    localparam int TS_MOD   = 1 << TS_WIDTH;

    logic                  clk;
    logic                  rst_n;
    logic                  en;
    logic                  clear;
    logic                  spike;
    logic                  out_valid;
    logic                  out_ready;
    logic [TS_WIDTH-1:0]   out_timestamp;
    logic [$clog2(DEPTH):0] fill_level;
    logic                  overflow;
    logic [7:0]            drop_count;

    int total;
    int bad;

    // Reference model state.
    int q[$];
    int m_ts;
    bit m_ovf;
    int m_drop;

    spike_event_logger #(.TS_WIDTH(TS_WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .clear         (clear),
        .spike         (spike),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_timestamp (out_timestamp),
        .fill_level    (fill_level),
        .overflow      (overflow),
        .drop_count    (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ts   = 0;
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    // Model of one clock edge, computed from the behavioural rules.
    task automatic model_step(input bit e, input bit s, input bit c, input bit r);
        int t;
        if (c) begin
            model_reset();
            return;
        end
        t = m_ts;
        if (e) m_ts = (m_ts + 1) % TS_MOD;
        if (r && q.size() > 0) void'(q.pop_front());
        if (e && s) begin
            if (q.size() < DEPTH) q.push_back(t);
            else begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
    endtask

    task automatic compare_all();
        check("valid", 32'(out_valid), 32'(q.size() > 0));
        check("fill", 32'(fill_level), 32'(q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("drops", 32'(drop_count), 32'(m_drop));
        if (q.size() > 0) check("head", 32'(out_timestamp), 32'(q[0]));
    endtask

    // Drive one cycle's inputs, let the edge happen, then compare.
    task automatic tick(input bit e, input bit s, input bit c, input bit r);
        en = e; spike = s; clear = c; out_ready = r;
        model_step(e, s, c, r);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic run_until_ts(input int target);
        while (m_ts != target) tick(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int exp_a[4];
        total = 0;
        bad   = 0;
        rst_n = 1'b0; en = 1'b0; clear = 1'b0; spike = 1'b0; out_ready = 1'b0;
        model_reset();
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_fill", 32'(fill_level), 32'd0);
        check("rst_ts_out", 32'(out_timestamp), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_drops", 32'(drop_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic capture at ts 3, 7, 10, then drain.
        while (m_ts <= 10) tick(1'b1, (m_ts == 3 || m_ts == 7 || m_ts == 10), 1'b0, 1'b0);
        check("basic_fill", 32'(fill_level), 32'd3);
        check("basic_head", 32'(out_timestamp), 32'd3);
        exp_a = '{3, 7, 10, 0};
        for (int i = 0; i < 3; i++) begin
            check("basic_seq", 32'(out_timestamp), 32'(exp_a[i]));
            tick(1'b1, 1'b0, 1'b0, 1'b1);
        end
        check("basic_empty", 32'(out_valid), 32'd0);

        // Overflow: six spikes into a four-entry FIFO.
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        while (m_ts <= 11) tick(1'b1, (m_ts % 2 == 1), 1'b0, 1'b0);
        check("ovf_fill", 32'(fill_level), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_drops", 32'(drop_count), 32'd2);
        check("ovf_head", 32'(out_timestamp), 32'd1);

        // Full FIFO: push and pop at the same edge.
        run_until_ts(20);
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        check("pp_fill", 32'(fill_level), 32'd4);
        check("pp_drops", 32'(drop_count), 32'd2);
        exp_a = '{3, 5, 7, 20};
        for (int i = 0; i < 4; i++) begin
            check("pp_seq", 32'(out_timestamp), 32'(exp_a[i]));
            tick(1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Timestamp wrap and enable gating.
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        run_until_ts(254);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("en0_drops", 32'(drop_count), 32'd0);
        check("en0_fill", 32'(fill_level), 32'd3);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        exp_a = '{254, 255, 0, 1};
        for (int i = 0; i < 4; i++) check("wrap_entry", 32'(dut.mem[(dut.rd_ptr + i) % DEPTH]), 32'(exp_a[i]));

        // Drop counter saturation, then clear with a coincident spike.
        for (int i = 0; i < 300; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
        check("sat_drops", 32'(drop_count), 32'd255);
        check("sat_ovf", 32'(overflow), 32'd1);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        check("clr_valid", 32'(out_valid), 32'd0);
        check("clr_fill", 32'(fill_level), 32'd0);
        check("clr_drops", 32'(drop_count), 32'd0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        check("clr_ts0", 32'(out_timestamp), 32'd0);

        // Asynchronous reset mid-cycle with entries queued.
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        check("pre_arst_fill", 32'(fill_level), 32'd3);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_fill", 32'(fill_level), 32'd0);
        #2 rst_n = 1'b1;
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        check("arst_ts0", 32'(out_timestamp), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
